// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester ports and memory-side bus of dmem_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface dmem_arbiter_if #(parameter int WIDTH = 32);
   logic             p0_req, p0_we, p0_done;
   logic [2:0]       p0_mode;
   logic [WIDTH-1:0] p0_addr, p0_wdata;
   logic             p1_req, p1_we, p1_done;
   logic [2:0]       p1_mode;
   logic [WIDTH-1:0] p1_addr, p1_wdata;
   logic [WIDTH-1:0] rdata, mem_addr, mem_wdata, mem_rdata;
   logic             err, busy, mem_we;
   logic [2:0]       mem_mode;
   logic [1:0]       mem_result_src;
   modport slave (
      input  p0_req, p0_we, p0_mode, p0_addr, p0_wdata,
      input  p1_req, p1_we, p1_mode, p1_addr, p1_wdata, mem_rdata,
      output p0_done, p1_done, rdata, err, busy,
      output mem_addr, mem_wdata, mem_we, mem_mode, mem_result_src
   );
   modport master (
      output p0_req, p0_we, p0_mode, p0_addr, p0_wdata,
      output p1_req, p1_we, p1_mode, p1_addr, p1_wdata, mem_rdata,
      input  p0_done, p1_done, rdata, err, busy,
      input  mem_addr, mem_wdata, mem_we, mem_mode, mem_result_src
   );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and IDLE/ACCESS/RESP access sequencer for the data memory.
// Define DMEM_ARB_RR_EN for round-robin tie-break; otherwise port 0 has fixed priority.
module dmem_arbiter #(
   parameter int WIDTH     = 32,
   parameter int ADDR_BITS = 17
) (
   input logic           clk,
   input logic           rst_n,
   dmem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   state_t           state, state_nx;
   logic             any, take, g, win, we_nx, we_q, err_nx, err_q;
   logic [2:0]       mode_nx, mode_q;
   logic [WIDTH-1:0] addr_nx, wdata_nx, addr_q, wdata_q, rdata_q;

   assign any  = bus.p0_req | bus.p1_req;
   assign take = (state == IDLE) && any;
`ifdef DMEM_ARB_RR_EN
   logic last;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) last <= 1'b1;
      else if (take) last <= g;
   assign g = (bus.p0_req && bus.p1_req) ? ~last : bus.p1_req;
`else
   assign g = ~bus.p0_req & bus.p1_req;
`endif
   assign we_nx    = g ? bus.p1_we    : bus.p0_we;
   assign mode_nx  = g ? bus.p1_mode  : bus.p0_mode;
   assign addr_nx  = g ? bus.p1_addr  : bus.p0_addr;
   assign wdata_nx = g ? bus.p1_wdata : bus.p0_wdata;
   assign err_nx   = (|addr_nx[1:0]) || ((addr_nx >> ADDR_BITS) != '0) ||
                     (mode_nx == 3'd0) || (mode_nx > 3'd5);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx           = state;
      bus.mem_we         = 1'b0;
      bus.mem_result_src = 2'b00;
      bus.p0_done        = 1'b0;
      bus.p1_done        = 1'b0;
      bus.err            = 1'b0;
      bus.busy           = 1'b0;
      state_nx           = state == IDLE ? (any ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;
      bus.mem_we         = (state == ACCESS) && we_q && !err_q;
      bus.mem_result_src = (state == ACCESS && !we_q && !err_q) ? 2'b01 : 2'b00;
      bus.p0_done        = (state == RESP) && !win;
      bus.p1_done        = (state == RESP) && win;
      bus.err            = (state == RESP) && err_q;
      bus.busy           = state != IDLE;
   end

   // Latched request fields double as the held mem_* outputs outside ACCESS.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         win     <= 1'b0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         mode_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         if (take) begin
            win     <= g;
            we_q    <= we_nx;
            err_q   <= err_nx;
            mode_q  <= mode_nx;
            addr_q  <= addr_nx;
            wdata_q <= wdata_nx;
         end
         if (state == ACCESS) rdata_q <= (!we_q && !err_q) ? bus.mem_rdata : '0;
      end

   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_mode  = mode_q;
   assign bus.rdata     = rdata_q;
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and access sequencer for the byte-addressed data memory. Port 0 is the core load/store path; port 1 is the loader/debug path. Each request is latched, driven onto the memory in one dedicated access cycle, and answered with a one-cycle done pulse carrying read data or an error. Requests the memory cannot serve are rejected before any write reaches the array.

## Interface
- WIDTH, 32, data and address width
- ADDR_BITS, 17, implemented memory size is 2**ADDR_BITS bytes
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- pN_req  in  1  request from port N (N = 0, 1); held until pN_done
- pN_we  in  1  1 = store, 0 = load
- pN_mode  in  3  001 word, 010 half, 011 byte, 100 half unsigned, 101 byte unsigned
- pN_addr  in  WIDTH  byte address
- pN_wdata  in  WIDTH  store data
- pN_done  out  1  one-cycle completion pulse for port N
- rdata  out  WIDTH  load data, valid while any pN_done is high
- err  out  1  request rejected, valid while any pN_done is high
- busy  out  1  high in ACCESS and RESP
- mem_addr  out  WIDTH  memory address
- mem_wdata  out  WIDTH  memory store data
- mem_we  out  1  memory write enable
- mem_mode  out  3  memory access mode
- mem_result_src  out  2  01 during a load access, 00 otherwise
- mem_rdata  in  WIDTH  combinational memory read result

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE with no request: stay in IDLE.
- IDLE with at least one request:
  - Select a winner (see Configuration).
  - Latch its we, mode, addr and wdata, and the winner index.
  - Compute the error flag. err = addr[1:0] != 0, or addr >= 2**ADDR_BITS, or mode not in 001..101.
  - Go to ACCESS.
- ACCESS:
  - mem_addr, mem_wdata and mem_mode are driven from the latched values.
  - mem_we = latched we & ~err.
  - mem_result_src = 01 if the request is a load without error.
  - At the end of the cycle, rdata captures mem_rdata for an error-free load and 0 otherwise. Go to RESP.
- RESP:
  - pN_done = 1 for the winner only; err = latched error flag.
  - mem_we = 0 and mem_result_src = 00.
  - Next state is IDLE.
- Requests are not sampled in ACCESS or RESP.
- The losing port's request stays pending. It is considered again in the next IDLE.
- Requester rule: the port keeps req and all fields stable from assertion until its done. In the cycle after done it must either drop req or present a new request.
- Outside ACCESS, the mem_* outputs hold their last driven values, except mem_we and mem_result_src.

## Timing
- Reset values:
  - All outputs 0.
  - The internal last-grant register resets to 1, so port 0 wins the first tie.
- Latency:
  - Request sampled in IDLE at cycle t.
  - Memory access in cycle t+1.
  - done, rdata and err valid in cycle t+2.
- Throughput: at most one access every 3 cycles. Back-to-back requests from one port complete at t+2, t+5, and so on.
- Simultaneous requests: exactly one grant per IDLE cycle; a done is never asserted for both ports.
- Store commit: a store commits at the rising edge that ends ACCESS. A store with err set never asserts mem_we.
- Reset mid-operation: rst_n low forces IDLE immediately and clears mem_we, done, err and busy. No partial write follows deassertion.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration. On a tie, the port not granted last wins. The last-grant register updates on every grant.
- DMEM_ARB_RR_EN undefined: fixed priority, port 0 always wins a tie. The last-grant register is not built.

## Test plan
- Store then load, port 0:
  - Stimulus: word store 0xDEADBEEF to 0x100, then word load from 0x100.
  - Required: mem_we high only in the store's ACCESS cycle; load returns rdata = 0xDEADBEEF with err = 0, done two cycles after sampling.
- Simultaneous requests, RR enabled:
  - Stimulus: both ports request continuously.
  - Required: done order p0, p1, p0, p1. With the macro undefined, port 0 wins every round.
- Error cases, each must give err = 1, rdata = 0 and no write:
  - word load at 0x102;
  - store to 0x20000;
  - mode 110.
- Reset mid-access:
  - Stimulus: assert rst_n low during ACCESS of a store to 0x200.
  - Required: mem_we drops the same cycle, no done, FSM in IDLE; a later load of 0x200 returns the old contents.
- Signed and unsigned loads:
  - Stimulus: byte store 0x80 to 0x40, then byte load and byte-unsigned load from 0x40.
  - Required: byte load returns 0xFFFFFF80; byte-unsigned load returns 0x00000080.
- Pending loser:
  - Stimulus: port 1 requests while port 0 is in ACCESS.
  - Required: port 1 is sampled in the next IDLE and gets done three cycles after port 0.
